lpc_cycle_decoder: RTL and testbench

Passive LPC bus snooper. It is the parametrised successor of the team's single-mode I/O decoder. It follows host-initiated I/O and memory cycles, reads and writes, through START/CYCTYPE/ADDR/TAR/SYNC/DATA/TAR, and handles wait states, sync errors, timeouts and LFRAME# aborts. Each completed cycle is reported as one record with a single-cycle valid pulse to the downstream capture/UART logic.

---
 rtl/lpc_cycle_decoder.sv | 206 ++++++++++++++++++++
 tb/tb_lpc_cycle_decoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lpc_cycle_decoder.sv
// Passive LPC snooper: follows host I/O and memory cycles and emits one record
// per completed cycle, or an abort pulse when the cycle is dropped.
module lpc_cycle_decoder #(
    parameter int ENABLE_MEM      = 1,
    parameter int SYNC_TIMEOUT    = 16,
    parameter int LONG_WAIT_LIMIT = 0
) (
    input  logic        lpc_clock,
    input  logic        lpc_reset,
    input  logic [3:0]  lpc_ad,
    input  logic        lpc_frame,
    output logic [3:0]  out_cyctype_dir,
    output logic [31:0] out_addr,
    output logic [7:0]  out_data,
    output logic        out_sync_err,
    output logic        out_valid,
    output logic        out_abort
);

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        START   = 4'd1,
        CYCTYPE = 4'd2,
        ADDR    = 4'd3,
        WDATA   = 4'd4,
        TAR1    = 4'd5,
        SYNC    = 4'd6,
        RDATA   = 4'd7,
        TAR2    = 4'd8
    } state_t;

    localparam logic [7:0] SHORT_MAX = 8'(SYNC_TIMEOUT);
    localparam logic [7:0] LONG_MAX  = 8'(LONG_WAIT_LIMIT);

    state_t      state_r, state_s;
    logic [2:0]  cnt_r, cnt_s;
    logic [3:0]  cyc_r, cyc_s;
    logic [31:0] addr_r, addr_s;
    logic [7:0]  data_r, data_s;
    logic        serr_r, serr_s;
    logic [7:0]  short_r, short_s;
    logic [7:0]  long_r, long_s;
    logic        valid_s;
    logic        abort_s;

    // Next-state, capture datapath and pulse decode for the bus follower.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        cyc_s   = cyc_r;
        addr_s  = addr_r;
        data_s  = data_r;
        serr_s  = serr_r;
        short_s = short_r;
        long_s  = long_r;
        valid_s = 1'b0;
        abort_s = 1'b0;
        if (state_r != IDLE && state_r != START && !lpc_frame) begin
            // LFRAME# mid-cycle; a 0000 nibble is already the next START
            abort_s = 1'b1;
            state_s = (lpc_ad == 4'b0000) ? START : IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!lpc_frame && lpc_ad == 4'b0000) state_s = START;
                    else                                 state_s = IDLE;
                end
                START: begin
                    if (!lpc_frame) begin
                        state_s = (lpc_ad == 4'b0000) ? START : IDLE;
                    end else begin
                        cyc_s  = lpc_ad;
                        addr_s = 32'd0;
                        serr_s = 1'b0;
                        if (lpc_ad[3:2] == 2'b00) begin
                            state_s = ADDR;
                            cnt_s   = 3'd3;
                        end else if (lpc_ad[3:2] == 2'b01 && ENABLE_MEM != 0) begin
                            state_s = ADDR;
                            cnt_s   = 3'd7;
                        end else begin
                            state_s = IDLE;
                        end
                    end
                end
                ADDR: begin
                    addr_s = {addr_r[27:0], lpc_ad};
                    if (cnt_r == 3'd0) begin
                        state_s = cyc_r[1] ? WDATA : TAR1;
                        cnt_s   = 3'd1;
                    end else begin
                        cnt_s = cnt_r - 3'd1;
                    end
                end
                WDATA, RDATA: begin
                    if (cnt_r == 3'd1) begin
                        data_s[3:0] = lpc_ad;
                        cnt_s       = 3'd0;
                    end else begin
                        data_s[7:4] = lpc_ad;
                        cnt_s       = 3'd1;
                        if (state_r == WDATA) begin
                            state_s = TAR1;
                        end else begin
                            valid_s = 1'b1;
                            state_s = TAR2;
                        end
                    end
                end
                TAR1: begin
                    if (cnt_r == 3'd0) begin
                        state_s = SYNC;
                        short_s = 8'd0;
                        long_s  = 8'd0;
                    end else begin
                        cnt_s = cnt_r - 3'd1;
                    end
                end
                SYNC: begin
                    case (lpc_ad)
                        4'b0000, 4'b1010: begin
                            serr_s = (lpc_ad == 4'b1010);
                            cnt_s  = 3'd1;
                            if (cyc_r[1]) begin
                                valid_s = 1'b1;
                                state_s = TAR2;
                            end else begin
                                state_s = RDATA;
                            end
                        end
                        4'b0101: begin
                            short_s = short_r + 8'd1;
                            if (short_s == SHORT_MAX) begin
                                abort_s = 1'b1;
                                state_s = IDLE;
                            end else begin
                                state_s = SYNC;
                            end
                        end
                        4'b0110: begin
                            long_s = long_r + 8'd1;
                            if (LONG_MAX != 8'd0 && long_s == LONG_MAX) begin
                                abort_s = 1'b1;
                                state_s = IDLE;
                            end else begin
                                state_s = SYNC;
                            end
                        end
                        default: begin
                            abort_s = 1'b1;
                            state_s = IDLE;
                        end
                    endcase
                end
                TAR2: begin
                    if (cnt_r == 3'd0) state_s = IDLE;
                    else               cnt_s   = cnt_r - 3'd1;
                end
                default: state_s = IDLE;
            endcase
        end
    end

    // State, capture registers and the record that only moves with out_valid.
    always_ff @(posedge lpc_clock or negedge lpc_reset) begin
        if (!lpc_reset) begin
            state_r         <= IDLE;
            cnt_r           <= 3'd0;
            cyc_r           <= 4'd0;
            addr_r          <= 32'd0;
            data_r          <= 8'd0;
            serr_r          <= 1'b0;
            short_r         <= 8'd0;
            long_r          <= 8'd0;
            out_cyctype_dir <= 4'd0;
            out_addr        <= 32'd0;
            out_data        <= 8'd0;
            out_sync_err    <= 1'b0;
            out_valid       <= 1'b0;
            out_abort       <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            cyc_r     <= cyc_s;
            addr_r    <= addr_s;
            data_r    <= data_s;
            serr_r    <= serr_s;
            short_r   <= short_s;
            long_r    <= long_s;
            out_valid <= valid_s;
            out_abort <= abort_s;
            if (valid_s) begin
                out_cyctype_dir <= cyc_s;
                out_addr        <= addr_s;
                out_data        <= data_s;
                out_sync_err    <= serr_s;
            end else begin
                out_cyctype_dir <= out_cyctype_dir;
                out_addr        <= out_addr;
                out_data        <= out_data;
                out_sync_err    <= out_sync_err;
            end
        end
    end

endmodule

// File: tb/tb_lpc_cycle_decoder.sv
// Directed bench: two decoders share one LPC bus, one with memory decode and
// tight wait limits, one with memory cycles disabled and default limits.
module tb_lpc_cycle_decoder;

    logic        lpc_clock = 1'b0;
    logic        lpc_reset;
    logic [3:0]  lpc_ad;
    logic        lpc_frame;

    logic [3:0]  a_cyc, b_cyc;
    logic [31:0] a_addr, b_addr;
    logic [7:0]  a_data, b_data;
    logic        a_serr, b_serr, a_valid, b_valid, a_abort, b_abort;

    int total = 0;
    int bad   = 0;
    int a_nv = 0, a_na = 0, b_nv = 0, b_na = 0, overlap = 0;

    always #15 lpc_clock = ~lpc_clock;

    lpc_cycle_decoder #(.ENABLE_MEM(1), .SYNC_TIMEOUT(4), .LONG_WAIT_LIMIT(3)) dut_a (
        .lpc_clock(lpc_clock), .lpc_reset(lpc_reset), .lpc_ad(lpc_ad), .lpc_frame(lpc_frame),
        .out_cyctype_dir(a_cyc), .out_addr(a_addr), .out_data(a_data),
        .out_sync_err(a_serr), .out_valid(a_valid), .out_abort(a_abort)
    );

    lpc_cycle_decoder #(.ENABLE_MEM(0), .SYNC_TIMEOUT(16), .LONG_WAIT_LIMIT(0)) dut_b (
        .lpc_clock(lpc_clock), .lpc_reset(lpc_reset), .lpc_ad(lpc_ad), .lpc_frame(lpc_frame),
        .out_cyctype_dir(b_cyc), .out_addr(b_addr), .out_data(b_data),
        .out_sync_err(b_serr), .out_valid(b_valid), .out_abort(b_abort)
    );

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge lpc_clock) begin
        if (a_valid) a_nv++;
        if (a_abort) a_na++;
        if (b_valid) b_nv++;
        if (b_abort) b_na++;
        if ((a_valid && a_abort) || (b_valid && b_abort)) overlap++;
    end

    task automatic nib(input logic f, input logic [3:0] a);
        @(negedge lpc_clock);
        lpc_frame = f;
        lpc_ad    = a;
    endtask

    task automatic settle();
        @(posedge lpc_clock);
        #5;
    endtask

    // Full host cycle; sync_final 0000/1010 completes it, anything else does not.
    task automatic lpc_cycle(input logic [3:0] cyc, input logic [31:0] addr, input int naddr,
                             input logic [7:0] data, input int nshort, input int nlong,
                             input logic [3:0] sync_final);
        nib(1'b0, 4'h0);
        nib(1'b1, cyc);
        for (int i = naddr - 1; i >= 0; i--) nib(1'b1, addr[4*i +: 4]);
        if (cyc[1]) begin
            nib(1'b1, data[3:0]);
            nib(1'b1, data[7:4]);
        end
        nib(1'b1, 4'hF);
        nib(1'b1, 4'hF);
        repeat (nshort) nib(1'b1, 4'h5);
        repeat (nlong) nib(1'b1, 4'h6);
        nib(1'b1, sync_final);
        if (!cyc[1] && (sync_final == 4'h0 || sync_final == 4'hA)) begin
            nib(1'b1, data[3:0]);
            nib(1'b1, data[7:4]);
        end
        repeat (4) nib(1'b1, 4'hF);
    endtask

    task automatic test_reset();
        lpc_reset = 1'b0;
        lpc_frame = 1'b1;
        lpc_ad    = 4'hF;
        repeat (3) settle();
        total++; if ({a_cyc, a_addr, a_data, a_serr, a_valid, a_abort} !== 47'd0) begin bad++; $display("FAIL reset_a got=%h exp=0", {a_cyc, a_addr, a_data, a_serr, a_valid, a_abort}); end
        total++; if ({b_cyc, b_addr, b_data, b_serr, b_valid, b_abort} !== 47'd0) begin bad++; $display("FAIL reset_b got=%h exp=0", {b_cyc, b_addr, b_data, b_serr, b_valid, b_abort}); end
        @(negedge lpc_clock);
        lpc_reset = 1'b1;
        settle();
    endtask

    task automatic test_io_write();
        int v0, a0;
        settle(); v0 = a_nv; a0 = a_na;
        lpc_cycle(4'h2, 32'h0080, 4, 8'h5A, 0, 0, 4'h0);
        settle();
        total++; if (a_nv - v0 !== 1) begin bad++; $display("FAIL io_write_valid got=%0d exp=1", a_nv - v0); end
        total++; if (a_na - a0 !== 0) begin bad++; $display("FAIL io_write_abort got=%0d exp=0", a_na - a0); end
        total++; if (a_cyc !== 4'h2) begin bad++; $display("FAIL io_write_cyc got=%h exp=2", a_cyc); end
        total++; if (a_addr !== 32'h00000080) begin bad++; $display("FAIL io_write_addr got=%h exp=00000080", a_addr); end
        total++; if (a_data !== 8'h5A) begin bad++; $display("FAIL io_write_data got=%h exp=5a", a_data); end
        total++; if (a_serr !== 1'b0) begin bad++; $display("FAIL io_write_serr got=%b exp=0", a_serr); end
    endtask

    task automatic test_io_read();
        int v0;
        settle(); v0 = a_nv;
        lpc_cycle(4'h0, 32'h03F8, 4, 8'hC1, 3, 0, 4'h0);
        settle();
        total++; if (a_nv - v0 !== 1) begin bad++; $display("FAIL io_read_valid got=%0d exp=1", a_nv - v0); end
        total++; if (a_cyc !== 4'h0) begin bad++; $display("FAIL io_read_cyc got=%h exp=0", a_cyc); end
        total++; if (a_addr !== 32'h000003F8) begin bad++; $display("FAIL io_read_addr got=%h exp=000003f8", a_addr); end
        total++; if (a_data !== 8'hC1) begin bad++; $display("FAIL io_read_data got=%h exp=c1", a_data); end
        total++; if (b_data !== 8'hC1) begin bad++; $display("FAIL io_read_data_b got=%h exp=c1", b_data); end
    endtask

    task automatic test_mem_read();
        int v0, bv0, ba0;
        settle(); v0 = a_nv; bv0 = b_nv; ba0 = b_na;
        lpc_cycle(4'h4, 32'hFFFFFFF0, 8, 8'h3E, 0, 0, 4'h0);
        settle();
        total++; if (a_nv - v0 !== 1) begin bad++; $display("FAIL mem_valid got=%0d exp=1", a_nv - v0); end
        total++; if (a_cyc !== 4'h4) begin bad++; $display("FAIL mem_cyc got=%h exp=4", a_cyc); end
        total++; if (a_addr !== 32'hFFFFFFF0) begin bad++; $display("FAIL mem_addr got=%h exp=fffffff0", a_addr); end
        total++; if (a_data !== 8'h3E) begin bad++; $display("FAIL mem_data got=%h exp=3e", a_data); end
        total++; if (b_nv - bv0 !== 0) begin bad++; $display("FAIL nomem_valid got=%0d exp=0", b_nv - bv0); end
        total++; if (b_na - ba0 !== 0) begin bad++; $display("FAIL nomem_abort got=%0d exp=0", b_na - ba0); end
        total++; if (b_addr !== 32'h000003F8) begin bad++; $display("FAIL nomem_hold_addr got=%h exp=000003f8", b_addr); end
    endtask

    task automatic test_timeout();
        int v0, a0, bv0;
        settle(); v0 = a_nv; a0 = a_na; bv0 = b_nv;
        lpc_cycle(4'h2, 32'h0010, 4, 8'h11, 4, 0, 4'h0);
        settle();
        total++; if (a_na - a0 !== 1) begin bad++; $display("FAIL timeout_abort got=%0d exp=1", a_na - a0); end
        total++; if (a_nv - v0 !== 0) begin bad++; $display("FAIL timeout_valid got=%0d exp=0", a_nv - v0); end
        total++; if (b_nv - bv0 !== 1) begin bad++; $display("FAIL timeout_b_valid got=%0d exp=1", b_nv - bv0); end
        v0 = a_nv;
        lpc_cycle(4'h2, 32'h0070, 4, 8'h33, 0, 0, 4'h0);
        settle();
        total++; if (a_nv - v0 !== 1) begin bad++; $display("FAIL after_timeout_valid got=%0d exp=1", a_nv - v0); end
        total++; if ({a_addr, a_data} !== {32'h00000070, 8'h33}) begin bad++; $display("FAIL after_timeout_rec got=%h exp=0000007033", {a_addr, a_data}); end
    endtask

    task automatic test_long_wait();
        int v0, a0, bv0;
        settle(); v0 = a_nv; a0 = a_na; bv0 = b_nv;
        lpc_cycle(4'h0, 32'h002E, 4, 8'h44, 0, 3, 4'h0);
        settle();
        total++; if (a_na - a0 !== 1) begin bad++; $display("FAIL long_abort got=%0d exp=1", a_na - a0); end
        total++; if (a_nv - v0 !== 0) begin bad++; $display("FAIL long_valid got=%0d exp=0", a_nv - v0); end
        total++; if (b_nv - bv0 !== 1) begin bad++; $display("FAIL long_b_valid got=%0d exp=1", b_nv - bv0); end
        total++; if (b_data !== 8'h44) begin bad++; $display("FAIL long_b_data got=%h exp=44", b_data); end
    endtask

    task automatic test_sync_err();
        int v0;
        settle(); v0 = a_nv;
        lpc_cycle(4'h2, 32'h0090, 4, 8'hFF, 0, 0, 4'hA);
        settle();
        total++; if (a_nv - v0 !== 1) begin bad++; $display("FAIL serr_valid got=%0d exp=1", a_nv - v0); end
        total++; if (a_serr !== 1'b1) begin bad++; $display("FAIL serr_flag got=%b exp=1", a_serr); end
        total++; if (a_data !== 8'hFF) begin bad++; $display("FAIL serr_data got=%h exp=ff", a_data); end
    endtask

    task automatic test_illegal_sync();
        int v0, a0, ba0;
        settle(); v0 = a_nv; a0 = a_na; ba0 = b_na;
        lpc_cycle(4'h2, 32'h0091, 4, 8'h12, 0, 0, 4'h3);
        settle();
        total++; if (a_na - a0 !== 1) begin bad++; $display("FAIL illegal_abort got=%0d exp=1", a_na - a0); end
        total++; if (b_na - ba0 !== 1) begin bad++; $display("FAIL illegal_abort_b got=%0d exp=1", b_na - ba0); end
        total++; if (a_nv - v0 !== 0) begin bad++; $display("FAIL illegal_valid got=%0d exp=0", a_nv - v0); end
    endtask

    task automatic test_frame_abort();
        int v0, a0;
        settle(); v0 = a_nv; a0 = a_na;
        // Abort with LFRAME# pattern 1111 during write data
        nib(1'b0, 4'h0); nib(1'b1, 4'h2);
        nib(1'b1, 4'h0); nib(1'b1, 4'h0); nib(1'b1, 4'h5); nib(1'b1, 4'h5);
        nib(1'b1, 4'h5); nib(1'b0, 4'hF); nib(1'b1, 4'hF); nib(1'b1, 4'hF);
        // Restart during address nibble 2, immediately followed by a full write
        nib(1'b0, 4'h0); nib(1'b1, 4'h2); nib(1'b1, 4'h0); nib(1'b0, 4'h0);
        lpc_cycle(4'h2, 32'h0060, 4, 8'hA5, 0, 0, 4'h0);
        settle();
        total++; if (a_na - a0 !== 2) begin bad++; $display("FAIL frame_abort_count got=%0d exp=2", a_na - a0); end
        total++; if (a_nv - v0 !== 1) begin bad++; $display("FAIL frame_abort_valid got=%0d exp=1", a_nv - v0); end
        total++; if (a_addr !== 32'h00000060) begin bad++; $display("FAIL frame_abort_addr got=%h exp=00000060", a_addr); end
        total++; if ({a_data, a_serr} !== {8'hA5, 1'b0}) begin bad++; $display("FAIL frame_abort_data got=%h exp=14a", {a_data, a_serr}); end
    endtask

    task automatic test_reset_mid_sync();
        int v0, a0;
        settle(); v0 = a_nv; a0 = a_na;
        nib(1'b0, 4'h0); nib(1'b1, 4'h2);
        nib(1'b1, 4'h0); nib(1'b1, 4'h0); nib(1'b1, 4'h4); nib(1'b1, 4'h4);
        nib(1'b1, 4'h7); nib(1'b1, 4'h7); nib(1'b1, 4'hF); nib(1'b1, 4'hF);
        nib(1'b1, 4'h5); nib(1'b1, 4'h5);
        @(posedge lpc_clock);
        #3 lpc_reset = 1'b0;
        #1;
        total++; if ({a_cyc, a_addr, a_data, a_serr, a_valid, a_abort} !== 47'd0) begin bad++; $display("FAIL midsync_reset got=%h exp=0", {a_cyc, a_addr, a_data, a_serr, a_valid, a_abort}); end
        nib(1'b1, 4'h0); nib(1'b1, 4'hF); nib(1'b1, 4'hF);
        @(negedge lpc_clock);
        lpc_reset = 1'b1;
        repeat (3) nib(1'b1, 4'hF);
        settle();
        total++; if ((a_nv - v0) + (a_na - a0) !== 0) begin bad++; $display("FAIL midsync_pulses got=%0d exp=0", (a_nv - v0) + (a_na - a0)); end
        lpc_cycle(4'h2, 32'h0064, 4, 8'h99, 0, 0, 4'h0);
        settle();
        total++; if ({a_addr, a_data} !== {32'h00000064, 8'h99}) begin bad++; $display("FAIL post_reset_rec got=%h exp=0000006499", {a_addr, a_data}); end
    endtask

    initial begin
        test_reset();
        test_io_write();
        test_io_read();
        test_mem_read();
        test_timeout();
        test_long_wait();
        test_sync_err();
        test_illegal_sync();
        test_frame_abort();
        test_reset_mid_sync();
        total++; if (overlap !== 0) begin bad++; $display("FAIL valid_abort_overlap got=%0d exp=0", overlap); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
